// File: rtl/drbg_byte_consumer.sv
// drbg_byte_consumer
// Converts wide Hash-DRBG words into one narrow chunk per video line for the
// line rotator. Two word buffers (active + pending) let the next word be
// requested while the current one is still being consumed, so the chunk
// stream runs without gaps. A frame start (V rising) discards everything
// because the generator reseeds there and old words belong to the old seed.
// DATA_WIDTH_IN must be an integer multiple of DATA_WIDTH_OUT.
module drbg_byte_consumer #(
   parameter int DATA_WIDTH_IN  = 256,
   parameter int DATA_WIDTH_OUT = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      H,
   input  logic                      V,
   input  logic [DATA_WIDTH_IN-1:0]  data_in,
   input  logic                      data_in_valid,
   input  logic                      generator_busy,
   output logic [DATA_WIDTH_OUT-1:0] data_out,
   output logic                      data_out_valid,
   output logic                      need_next
);

   localparam int CHUNKS = DATA_WIDTH_IN / DATA_WIDTH_OUT;
   localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

   // Word buffers and their bookkeeping
   logic [DATA_WIDTH_IN-1:0]  r_active;
   logic [DATA_WIDTH_IN-1:0]  r_pending;
   logic [IDX_W-1:0]          r_idx;
   logic                      r_act_valid;
   logic                      r_pend_valid;
   logic                      r_req_out;

   // Sync flag history for edge detection
   logic                      r_h_d;
   logic                      r_v_d;

   // Registered outputs
   logic [DATA_WIDTH_OUT-1:0] r_data_out;
   logic                      r_data_out_valid;
   logic                      r_need_next;

   // Decoded events
   logic                      w_flush;
   logic                      w_advance;
   logic                      w_accept;
   logic                      w_issue;
   logic                      w_last;
   logic [DATA_WIDTH_OUT-1:0] w_chunk;

   // Next-state values
   logic [DATA_WIDTH_IN-1:0]  w_active_nxt;
   logic [DATA_WIDTH_IN-1:0]  w_pending_nxt;
   logic [IDX_W-1:0]          w_idx_nxt;
   logic                      w_act_valid_nxt;
   logic                      w_pend_valid_nxt;
   logic                      w_req_out_nxt;

   // Frame start: the generator reseeds, so every buffered word is stale.
   assign w_flush   = V & ~r_v_d;
   // New line: H rising outside vertical blanking.
   assign w_advance = H & ~r_h_d & ~V;
   // A returned word only counts when we actually asked for it.
   assign w_accept  = data_in_valid & r_req_out;
   // Ask for a word whenever the pending slot is free and nothing is in flight.
   assign w_issue   = ~r_pend_valid & ~r_req_out & ~generator_busy & ~w_flush;
   assign w_last    = (r_idx == LAST_IDX);
   // Chunks are handed out LSB first.
   assign w_chunk   = r_active[int'(r_idx) * DATA_WIDTH_OUT +: DATA_WIDTH_OUT];

   // Buffer update: flush first, then accept / advance / wrap handling.
   always_comb begin
      // NOTE: every signal assigned here starts from its hold value, so no
      // branch can leave one unassigned and imply a latch.
      w_active_nxt     = r_active;
      w_pending_nxt    = r_pending;
      w_idx_nxt        = r_idx;
      w_act_valid_nxt  = r_act_valid;
      w_pend_valid_nxt = r_pend_valid;
      w_req_out_nxt    = r_req_out;

      if (w_flush) begin
         // Flush wins over any accept or advance on the same cycle; a word
         // still in flight is dropped because req_out is cleared.
         w_act_valid_nxt  = 1'b0;
         w_pend_valid_nxt = 1'b0;
         w_req_out_nxt    = 1'b0;
         w_idx_nxt        = '0;
      end else begin
         if (w_accept) begin
            w_req_out_nxt = 1'b0;
         end else if (w_issue) begin
            w_req_out_nxt = 1'b1;
         end

         if (!r_act_valid) begin
            // Nothing to show: an arriving word becomes active immediately,
            // and a line advance has nothing to step through.
            if (w_accept) begin
               w_active_nxt    = data_in;
               w_idx_nxt       = '0;
               w_act_valid_nxt = 1'b1;
            end
         end else if (w_advance && !w_last) begin
            w_idx_nxt = r_idx + IDX_W'(1);
            if (w_accept) begin
               w_pending_nxt    = data_in;
               w_pend_valid_nxt = 1'b1;
            end
         end else if (w_advance) begin
            // Last chunk consumed: swap in the pending word, else take the
            // word arriving right now, else run dry.
            if (r_pend_valid) begin
               w_active_nxt     = r_pending;
               w_idx_nxt        = '0;
               w_pend_valid_nxt = 1'b0;
            end else if (w_accept) begin
               w_active_nxt = data_in;
               w_idx_nxt    = '0;
            end else begin
               w_act_valid_nxt = 1'b0;
            end
         end else if (w_accept) begin
            w_pending_nxt    = data_in;
            w_pend_valid_nxt = 1'b1;
         end
      end
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the word buffers are cleared too; they are plain registers
         // and a known value after reset keeps data_out deterministic.
         r_active         <= '0;
         r_pending        <= '0;
         r_idx            <= '0;
         r_act_valid      <= 1'b0;
         r_pend_valid     <= 1'b0;
         r_req_out        <= 1'b0;
         r_h_d            <= 1'b0;
         r_v_d            <= 1'b0;
         r_data_out       <= '0;
         r_data_out_valid <= 1'b0;
         r_need_next      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge state, independent of statement order.
         r_active         <= w_active_nxt;
         r_pending        <= w_pending_nxt;
         r_idx            <= w_idx_nxt;
         r_act_valid      <= w_act_valid_nxt;
         r_pend_valid     <= w_pend_valid_nxt;
         r_req_out        <= w_req_out_nxt;
         r_h_d            <= H;
         r_v_d            <= V;
         r_need_next      <= w_issue;
         // data_out freezes on its last chunk whenever no word is active.
         if (r_act_valid) begin
            r_data_out <= w_chunk;
         end
         r_data_out_valid <= r_act_valid;
      end
   end

   assign data_out       = r_data_out;
   assign data_out_valid = r_data_out_valid;
   assign need_next      = r_need_next;

   // The request strobe is a single-cycle pulse.
   a_need_pulse: assert property (@(posedge clk) disable iff (reset)
      need_next |=> !need_next);

   // At most one word is ever owed: no request while the pending slot is full.
   a_one_outstanding: assert property (@(posedge clk) disable iff (reset)
      !(r_req_out && r_pend_valid));

endmodule

// File: tb/tb_drbg_byte_consumer.sv
// Testbench for drbg_byte_consumer: reset/first-word table, directed
// sequences for wrap, underrun, flush and ignored-data corners, then random
// traffic compared against a queue-based reference model.
module tb_drbg_byte_consumer;

   localparam int DIN    = 256;
   localparam int DOUT   = 8;
   localparam int CHUNKS = DIN / DOUT;

   logic            clk;
   logic            rst;
   logic            h_in;
   logic            v_in;
   logic [DIN-1:0]  din_in;
   logic            dv_in;
   logic            busy_in;
   logic [DOUT-1:0] data_out;
   logic            data_out_valid;
   logic            need_next;

   int n_cmp;
   int n_err;

   drbg_byte_consumer #(
      .DATA_WIDTH_IN (DIN),
      .DATA_WIDTH_OUT(DOUT)
   ) dut (
      .clk           (clk),
      .reset         (rst),
      .H             (h_in),
      .V             (v_in),
      .data_in       (din_in),
      .data_in_valid (dv_in),
      .generator_busy(busy_in),
      .data_out      (data_out),
      .data_out_valid(data_out_valid),
      .need_next     (need_next)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Active word is a queue of chunks still to be shown (front = current),
   // pending word is held whole. Outputs are what the DUT should show after
   // the edge being modelled.
   logic [DOUT-1:0] m_act_q[$];
   logic [DIN-1:0]  m_pend_w;
   logic            m_pend_has;
   logic            m_req;
   logic            m_h_prev;
   logic            m_v_prev;
   logic [DOUT-1:0] m_dout;
   logic            m_valid;
   logic            m_need;

   task automatic load_act(input logic [DIN-1:0] w);
      m_act_q.delete();
      for (int i = 0; i < CHUNKS; i++) m_act_q.push_back(w[i*DOUT +: DOUT]);
   endtask

   always @(posedge clk) begin : ref_model
      logic flush, adv, acc, issue, used;
      if (rst) begin
         m_act_q.delete();
         m_pend_w   = '0;
         m_pend_has = 1'b0;
         m_req      = 1'b0;
         m_h_prev   = 1'b0;
         m_v_prev   = 1'b0;
         m_dout     = '0;
         m_valid    = 1'b0;
         m_need     = 1'b0;
      end else begin
         flush = v_in && !m_v_prev;
         adv   = h_in && !m_h_prev && !v_in;
         acc   = dv_in && m_req;
         issue = !m_pend_has && !m_req && !busy_in && !flush;
         if (m_act_q.size() != 0) m_dout = m_act_q[0];
         m_valid = (m_act_q.size() != 0);
         m_need  = issue;
         if (flush) begin
            m_act_q.delete();
            m_pend_has = 1'b0;
            m_req      = 1'b0;
         end else begin
            if (acc)   m_req = 1'b0;
            if (issue) m_req = 1'b1;
            if (m_act_q.size() == 0) begin
               if (acc) load_act(din_in);
            end else begin
               used = 1'b0;
               if (adv) begin
                  void'(m_act_q.pop_front());
                  if (m_act_q.size() == 0) begin
                     if (m_pend_has) begin
                        load_act(m_pend_w);
                        m_pend_has = 1'b0;
                     end else if (acc) begin
                        load_act(din_in);
                        used = 1'b1;
                     end
                  end
               end
               if (acc && !used) begin
                  m_pend_w   = din_in;
                  m_pend_has = 1'b1;
               end
            end
         end
         m_h_prev = h_in;
         m_v_prev = v_in;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [DIN-1:0] act, input logic [DIN-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: from a falling edge through the rising edge to the next falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_h();
      h_in = 1'b1; tick();
      h_in = 1'b0; tick();
   endtask

   function automatic logic [DIN-1:0] make_word(input logic [7:0] base);
      logic [DIN-1:0] w;
      for (int i = 0; i < CHUNKS; i++) w[i*DOUT +: DOUT] = base + 8'(i);
      return w;
   endfunction

   typedef struct {
      logic       rst;
      logic       h;
      logic       v;
      logic       dv;
      logic       busy;
      logic [1:0] wsel;
      logic [7:0] e_dout;
      logic       e_valid;
      logic       e_need;
   } vec_t;

   vec_t tbl[12];

   logic [DIN-1:0] word_a, word_b, word_c, word_d, word_e, word_f;
   int             v_hold;
   int             b_hold;

   initial begin
      n_cmp = 0;
      n_err = 0;
      word_a = make_word(8'h01);   // bytes 01..20
      word_b = make_word(8'h80);   // bytes 80..9F
      word_c = make_word(8'h40);
      word_d = make_word(8'hC0);
      word_e = make_word(8'h60);
      word_f = make_word(8'hA0);

      //          rst h  v  dv busy sel dout   valid need
      tbl[0]  = '{1, 0, 0, 0, 0,   0, 8'h00, 0,    0};
      tbl[1]  = '{1, 0, 0, 0, 0,   0, 8'h00, 0,    0};
      tbl[2]  = '{1, 0, 0, 0, 0,   0, 8'h00, 0,    0};
      tbl[3]  = '{0, 0, 0, 0, 0,   0, 8'h00, 0,    1};  // first request
      tbl[4]  = '{0, 0, 0, 0, 0,   0, 8'h00, 0,    0};  // one-cycle pulse
      tbl[5]  = '{0, 0, 0, 1, 0,   1, 8'h00, 0,    0};  // word A accepted
      tbl[6]  = '{0, 0, 0, 0, 0,   0, 8'h01, 1,    1};  // chunk 0, second request
      tbl[7]  = '{0, 0, 0, 0, 0,   0, 8'h01, 1,    0};
      tbl[8]  = '{0, 1, 0, 0, 0,   0, 8'h01, 1,    0};  // H rises
      tbl[9]  = '{0, 0, 0, 0, 0,   0, 8'h02, 1,    0};  // chunk 1
      tbl[10] = '{0, 0, 0, 1, 0,   2, 8'h02, 1,    0};  // word B to pending
      tbl[11] = '{0, 0, 0, 0, 0,   0, 8'h02, 1,    0};

      rst = 1'b1; h_in = 1'b0; v_in = 1'b0; dv_in = 1'b0; busy_in = 1'b0; din_in = '0;

      // ---- reset and first words ----
      for (int i = 0; i < 12; i++) begin
         rst     = tbl[i].rst;
         h_in    = tbl[i].h;
         v_in    = tbl[i].v;
         dv_in   = tbl[i].dv;
         busy_in = tbl[i].busy;
         din_in  = (tbl[i].wsel == 2'd1) ? word_a : (tbl[i].wsel == 2'd2) ? word_b : '0;
         tick();
         check($sformatf("tbl%0d data_out", i),  data_out,       tbl[i].e_dout);
         check($sformatf("tbl%0d valid", i),     data_out_valid, tbl[i].e_valid);
         check($sformatf("tbl%0d need_next", i), need_next,      tbl[i].e_need);
      end
      dv_in = 1'b0; din_in = '0;

      // ---- walk through word A, wrap into pending word B without a gap ----
      for (int k = 2; k < CHUNKS; k++) begin
         pulse_h();
         check("walk A data_out", data_out, word_a[k*DOUT +: DOUT]);
         check("walk A valid", data_out_valid, 1'b1);
      end
      h_in = 1'b1; tick();
      check("wrap A last chunk", data_out, 8'h20);
      check("wrap A valid", data_out_valid, 1'b1);
      check("wrap A no request yet", need_next, 1'b0);
      h_in = 1'b0; tick();
      check("wrap B first chunk", data_out, 8'h80);
      check("wrap B valid", data_out_valid, 1'b1);
      check("refill request", need_next, 1'b1);
      tick();
      check("refill request pulse", need_next, 1'b0);

      // ---- underrun: consume B with no pending word ----
      busy_in = 1'b1;
      for (int k = 1; k < CHUNKS; k++) begin
         pulse_h();
         check("walk B data_out", data_out, word_b[k*DOUT +: DOUT]);
      end
      h_in = 1'b1; tick();
      check("underrun wrap valid", data_out_valid, 1'b1);
      h_in = 1'b0; tick();
      check("underrun valid", data_out_valid, 1'b0);
      check("underrun hold", data_out, 8'h9F);
      pulse_h();
      pulse_h();
      check("underrun H ignored data", data_out, 8'h9F);
      check("underrun H ignored valid", data_out_valid, 1'b0);

      // ---- flush mid-word with a word arriving on the flush cycle ----
      busy_in = 1'b0; dv_in = 1'b1; din_in = word_c; tick();
      dv_in = 1'b0; tick();
      check("word C loaded", data_out, 8'h40);
      check("word C valid", data_out_valid, 1'b1);
      check("pending request", need_next, 1'b1);
      busy_in = 1'b1;
      pulse_h();
      pulse_h();
      check("word C chunk 2", data_out, 8'h42);
      v_in = 1'b1; dv_in = 1'b1; din_in = word_d; tick();
      dv_in = 1'b0; tick();
      check("flush valid", data_out_valid, 1'b0);
      check("flush hold", data_out, 8'h42);
      check("flush no request", need_next, 1'b0);
      tick();
      tick();
      check("busy blocks request", need_next, 1'b0);
      check("dropped word stays dropped", data_out_valid, 1'b0);
      busy_in = 1'b0; tick();
      check("request after flush", need_next, 1'b1);

      // ---- unrequested data ignored; H during V blanking ignored ----
      busy_in = 1'b1; dv_in = 1'b1; din_in = word_e; tick();
      dv_in = 1'b0; tick();
      check("word E loaded", data_out, 8'h60);
      check("word E valid", data_out_valid, 1'b1);
      check("no request while busy", need_next, 1'b0);
      dv_in = 1'b1; din_in = word_f; tick();
      dv_in = 1'b0;
      pulse_h();
      check("H in V blanking", data_out, 8'h60);
      v_in = 1'b0; tick();
      pulse_h();
      check("H after blanking", data_out, 8'h61);
      for (int k = 2; k < CHUNKS; k++) pulse_h();
      check("word E last chunk", data_out, 8'h7F);
      h_in = 1'b1; tick();
      h_in = 1'b0; tick();
      check("unrequested word not pending", data_out_valid, 1'b0);
      check("unrequested hold", data_out, 8'h7F);

      // ---- random traffic against the reference model ----
      v_hold = 0;
      b_hold = 0;
      for (int c = 0; c < 3000; c++) begin
         rst  = ($urandom_range(0, 399) == 0);
         h_in = ($urandom_range(0, 2) == 0);
         if (v_hold > 0) begin
            v_in = 1'b1;
            v_hold--;
         end else if ($urandom_range(0, 199) == 0) begin
            v_in   = 1'b1;
            v_hold = $urandom_range(1, 8);
         end else begin
            v_in = 1'b0;
         end
         if (b_hold > 0) begin
            busy_in = 1'b1;
            b_hold--;
         end else if ($urandom_range(0, 99) == 0) begin
            busy_in = 1'b1;
            b_hold  = $urandom_range(20, 200);
         end else begin
            busy_in = ($urandom_range(0, 3) == 0);
         end
         dv_in = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         for (int j = 0; j < DIN / 32; j++) din_in[j*32 +: 32] = $urandom();
         tick();
         check("rand data_out", data_out, m_dout);
         check("rand valid", data_out_valid, m_valid);
         check("rand need_next", need_next, m_need);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
